// File: rtl/fm_stream_feeder.sv
// Feature-map / weight source for the DSP-cascade PE: random-access pixel store,
// serial weight loader, and a zero-padded row-major streamer with a flush tail.
module fm_stream_feeder #(
    parameter int KERNEL_SIZE  = 3,
    parameter int FM_SIZE      = 3,
    parameter int PADDING      = 0,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst_n,
    input  logic                                    i_wr_en,
    input  logic [$clog2(FM_SIZE*FM_SIZE)-1:0]      i_wr_addr,
    input  logic signed [29:0]                      i_wr_data,
    input  logic                                    i_w_valid,
    input  logic signed [17:0]                      i_w_data,
    output logic                                    o_w_ready,
    input  logic                                    i_start,
    output logic                                    o_busy,
    output logic                                    o_done,
    output logic                                    o_en,
    output logic signed [29:0]                      o_DataFM,
    output logic [KERNEL_SIZE*KERNEL_SIZE*18-1:0]   o_Weight,
    output logic [1:0]                              o_state
);

    localparam int PS   = FM_SIZE + 2 * PADDING;
    localparam int NPIX = FM_SIZE * FM_SIZE;
    localparam int KK   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int AW   = $clog2(NPIX);
    localparam int CW   = $clog2(PS + 1);
    localparam int WCW  = (KK > 1) ? $clog2(KK) : 1;
    localparam int FW   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [CW-1:0]  PS_LAST = CW'(PS - 1);
    localparam logic [CW-1:0]  PAD_W   = CW'(PADDING);
    localparam logic [CW-1:0]  FM_W    = CW'(FM_SIZE);
    localparam logic [AW:0]    NPIX_W  = (AW + 1)'(NPIX);
    localparam logic [WCW-1:0] W_LAST  = WCW'(KK - 1);
    localparam logic [FW-1:0]  F_LAST  = FW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    // Weight port handshake: a word transfers on any rising edge where
    // i_w_valid and o_w_ready are both high; o_w_ready is high only in IDLE.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]  r_q, c_q;
    logic [FW-1:0]  f_q;
    logic [WCW-1:0] w_cnt_q;
    logic           w_loaded_q;
    logic [17:0]    w_q [KK];
    logic [29:0]    mem [NPIX];

    logic           en_q, en_d;
    logic [29:0]    data_q, data_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic           ready_q, ready_d;

    logic           start_ok, last_px, f_last, w_xfer, wr_ok, in_win;
    logic [CW-1:0]  r_off, c_off;
    logic [AW-1:0]  rd_addr;
    logic [29:0]    pix;

    assign start_ok = i_start && w_loaded_q;
    assign last_px  = (r_q == PS_LAST) && (c_q == PS_LAST);
    assign f_last   = (f_q == F_LAST);
    assign w_xfer   = i_w_valid && ready_q;
    assign wr_ok    = i_wr_en && (state_q == S_IDLE) && ({1'b0, i_wr_addr} < NPIX_W);

    // Positions left of/above the border wrap to large values, so one
    // unsigned compare per axis decides whether we are inside the map.
    always_comb begin
        r_off   = r_q - PAD_W;
        c_off   = c_q - PAD_W;
        in_win  = (r_off < FM_W) && (c_off < FM_W);
        rd_addr = AW'(int'(r_off) * FM_SIZE + int'(c_off));
        pix     = in_win ? mem[rd_addr] : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (last_px) state_d = (FLUSH_CYCLES > 0) ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                if (f_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered one edge behind the state that produces them,
    // so o_done fires on the first IDLE edge after the enable was high.
    always_comb begin
        en_d    = (state_q == S_STREAM) || (state_q == S_FLUSH);
        data_d  = (state_q == S_STREAM) ? pix : '0;
        done_d  = (state_q == S_IDLE) && en_q;
        busy_d  = (state_q != S_IDLE) || (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en_q    <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            en_q    <= en_d;
            data_q  <= data_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
            c_q <= '0;
            f_q <= '0;
        end else begin
            case (state_q)
                S_STREAM: begin
                    if (c_q == PS_LAST) begin
                        c_q <= '0;
                        r_q <= (r_q == PS_LAST) ? '0 : r_q + CW'(1);
                    end else begin
                        c_q <= c_q + CW'(1);
                    end
                end
                S_FLUSH: f_q <= f_q + FW'(1);
                default: begin
                    r_q <= '0;
                    c_q <= '0;
                    f_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_cnt_q    <= '0;
            w_loaded_q <= 1'b0;
            for (int k = 0; k < KK; k++) w_q[k] <= '0;
        end else if (w_xfer) begin
            w_q[w_cnt_q] <= i_w_data;
            if (w_cnt_q == W_LAST) begin
                w_cnt_q    <= '0;
                w_loaded_q <= 1'b1;
            end else begin
                w_cnt_q <= w_cnt_q + WCW'(1);
            end
        end
    end

    // Pixel store survives reset so a frame can be replayed after reloading weights.
    always_ff @(posedge i_clk) begin
        if (wr_ok) mem[i_wr_addr] <= i_wr_data;
    end

    for (genvar k = 0; k < KK; k++) begin : g_wbus
        assign o_Weight[k*18 +: 18] = w_q[k];
    end

    assign o_en      = en_q;
    assign o_DataFM  = data_q;
    assign o_done    = done_q;
    assign o_busy    = busy_q;
    assign o_w_ready = ready_q;
    assign o_state   = state_q;

endmodule
